// File: rtl/ethernet_fcs_pkg.sv
// rtl/ethernet_fcs_pkg.sv - CRC-32 constants, byte update function and FSM states for the RX FCS checker
package ethernet_fcs_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        TAIL
    } fsm_state_e;

    // Reflected CRC-32, LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ethernet_crc32_step.sv
// rtl/ethernet_crc32_step.sv - combinational CRC-32 update over the kept bytes of one beat
module ethernet_crc32_step
    import ethernet_fcs_pkg::*;
#(
    parameter int bytes_p = 4
) (
    input  logic [31:0]          crc_i,
    input  logic [8*bytes_p-1:0] data_i,
    input  logic [bytes_p-1:0]   keep_i,
    output logic [31:0]          crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int i = 0; i < bytes_p; i++) begin
            if (keep_i[i]) begin
                crc_o = crc32_byte(crc_o, data_i[8*i +: 8]);
            end
        end
    end

endmodule

// File: rtl/ethernet_rx_fcs_checker.sv
// rtl/ethernet_rx_fcs_checker.sv - checks and strips the Ethernet FCS, flags bad frames with tuser on tlast
// Statistics counters are present only when ETHERNET_RX_FCS_STATS_EN is defined.
module ethernet_rx_fcs_checker
    import ethernet_fcs_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int min_frame_p  = 64,
    parameter int max_frame_p  = 1518,
    parameter int stat_width_p = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [data_width_p-1:0]   mac_axis_tdata_i,
    input  logic [data_width_p/8-1:0] mac_axis_tkeep_i,
    input  logic                      mac_axis_tvalid_i,
    output logic                      mac_axis_tready_o,
    input  logic                      mac_axis_tlast_i,
    input  logic                      mac_axis_tuser_i,
    output logic [data_width_p-1:0]   rx_axis_tdata_o,
    output logic [data_width_p/8-1:0] rx_axis_tkeep_o,
    output logic                      rx_axis_tvalid_o,
    input  logic                      rx_axis_tready_i,
    output logic                      rx_axis_tlast_o,
    output logic                      rx_axis_tuser_o
`ifdef ETHERNET_RX_FCS_STATS_EN
    ,
    output logic [stat_width_p-1:0]   fcs_err_count_o,
    output logic [stat_width_p-1:0]   len_err_count_o
`endif
);

    localparam int B  = data_width_p / 8;
    localparam int KW = $clog2(B) + 1;
    localparam int CW = $clog2(max_frame_p + 2) + 1;

    if ((data_width_p != 32 && data_width_p != 64) || stat_width_p < 1) begin : g_bad_param
        $error("ethernet_rx_fcs_checker: data_width_p must be 32 or 64");
    end

    function automatic logic [B-1:0] keep_mask(input int k);
        logic [B-1:0] m;
        for (int i = 0; i < B; i++) m[i] = (i < k);
        return m;
    endfunction

    fsm_state_e              state_q;
    logic                    run_q;
    logic [data_width_p-1:0] h_data_q;
    logic [B-1:0]            h_keep_q;
    logic                    h_user_q;
    logic [31:0]             crc_q;
    logic [31:0]             crc_next;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_next;
    logic [CW:0]             cnt_sum;
    logic [KW-1:0]           n_kept;
    logic                    out_free;
    logic                    accept;
    logic                    fcs_bad;
    logic                    len_bad;
    logic                    frame_bad;

    ethernet_crc32_step #(.bytes_p(B)) u_crc (
        .crc_i  (crc_q),
        .data_i (mac_axis_tdata_i),
        .keep_i (mac_axis_tkeep_i),
        .crc_o  (crc_next)
    );

    always_comb begin
        n_kept = '0;
        for (int i = 0; i < B; i++) n_kept = n_kept + KW'(mac_axis_tkeep_i[i]);
    end

    assign out_free          = ~rx_axis_tvalid_o | rx_axis_tready_i;
    // run_q keeps the input closed while reset is asserted and for the first cycle after it.
    assign mac_axis_tready_o = run_q & (state_q != TAIL) & out_free;
    assign accept            = mac_axis_tvalid_i & mac_axis_tready_o;

    assign cnt_sum   = {1'b0, cnt_q} + (CW+1)'(n_kept);
    assign cnt_next  = (cnt_sum > (CW+1)'(max_frame_p + 1)) ? CW'(max_frame_p + 1) : cnt_sum[CW-1:0];
    assign fcs_bad   = (crc_next != CRC_RESIDUE);
    assign len_bad   = (cnt_next < CW'(min_frame_p)) | (cnt_next > CW'(max_frame_p));
    assign frame_bad = mac_axis_tuser_i | fcs_bad | len_bad;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= IDLE;
            run_q            <= 1'b0;
            h_data_q         <= '0;
            h_keep_q         <= '0;
            h_user_q         <= 1'b0;
            crc_q            <= CRC_INIT;
            cnt_q            <= '0;
            rx_axis_tdata_o  <= '0;
            rx_axis_tkeep_o  <= '0;
            rx_axis_tvalid_o <= 1'b0;
            rx_axis_tlast_o  <= 1'b0;
            rx_axis_tuser_o  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (out_free) rx_axis_tvalid_o <= 1'b0;
            if (accept) begin
                crc_q <= mac_axis_tlast_i ? CRC_INIT : crc_next;
                cnt_q <= mac_axis_tlast_i ? '0 : cnt_next;
            end
            case (state_q)
                IDLE: if (accept) begin
                    if (mac_axis_tlast_i) begin
                        // A single-beat frame cannot hold both data and FCS: pass it through as bad.
                        rx_axis_tvalid_o <= 1'b1;
                        rx_axis_tdata_o  <= mac_axis_tdata_i;
                        rx_axis_tkeep_o  <= mac_axis_tkeep_i;
                        rx_axis_tlast_o  <= 1'b1;
                        rx_axis_tuser_o  <= 1'b1;
                    end else begin
                        h_data_q <= mac_axis_tdata_i;
                        state_q  <= HOLD;
                    end
                end
                HOLD: if (accept) begin
                    rx_axis_tvalid_o <= 1'b1;
                    rx_axis_tdata_o  <= h_data_q;
                    if (!mac_axis_tlast_i || n_kept > KW'(4)) begin
                        rx_axis_tkeep_o <= '1;
                        rx_axis_tlast_o <= 1'b0;
                        rx_axis_tuser_o <= 1'b0;
                        h_data_q        <= mac_axis_tdata_i;
                        if (mac_axis_tlast_i) begin
                            h_keep_q <= keep_mask(int'(n_kept) - 4);
                            h_user_q <= frame_bad;
                            state_q  <= TAIL;
                        end
                    end else begin
                        // FCS straddles the held beat: trim its last 4-n bytes.
                        rx_axis_tkeep_o <= keep_mask(B - 4 + int'(n_kept));
                        rx_axis_tlast_o <= 1'b1;
                        rx_axis_tuser_o <= frame_bad;
                        state_q         <= IDLE;
                    end
                end
                TAIL: if (out_free) begin
                    rx_axis_tvalid_o <= 1'b1;
                    rx_axis_tdata_o  <= h_data_q;
                    rx_axis_tkeep_o  <= h_keep_q;
                    rx_axis_tlast_o  <= 1'b1;
                    rx_axis_tuser_o  <= h_user_q;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ETHERNET_RX_FCS_STATS_EN
    logic h_fcs_q;
    logic h_len_q;
    logic stat_fire;
    logic stat_fcs;
    logic stat_len;

    always_comb begin
        stat_fire = 1'b0;
        stat_fcs  = 1'b0;
        stat_len  = 1'b0;
        if (state_q == TAIL) begin
            stat_fire = out_free;
            stat_fcs  = h_fcs_q;
            stat_len  = h_len_q;
        end else if (accept && mac_axis_tlast_i && (state_q == IDLE || n_kept <= KW'(4))) begin
            stat_fire = 1'b1;
            stat_fcs  = fcs_bad;
            stat_len  = len_bad;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            h_fcs_q         <= 1'b0;
            h_len_q         <= 1'b0;
            fcs_err_count_o <= '0;
            len_err_count_o <= '0;
        end else begin
            if (accept && mac_axis_tlast_i) begin
                h_fcs_q <= fcs_bad;
                h_len_q <= len_bad;
            end
            if (stat_fire && stat_fcs && fcs_err_count_o != '1)
                fcs_err_count_o <= fcs_err_count_o + stat_width_p'(1);
            if (stat_fire && stat_len && len_err_count_o != '1)
                len_err_count_o <= len_err_count_o + stat_width_p'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ethernet_rx_fcs_checker.sv
// tb/tb_ethernet_rx_fcs_checker.sv - scoreboard bench for ethernet_rx_fcs_checker at 32- and 64-bit widths
module tb_ethernet_rx_fcs_checker;

    typedef logic [7:0] byte_q [$];
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b1;

    logic [31:0] m32_data = '0;
    logic [3:0]  m32_keep = '0;
    logic        m32_valid = 1'b0, m32_ready, m32_last = 1'b0, m32_user = 1'b0;
    logic [31:0] o32_data;
    logic [3:0]  o32_keep;
    logic        o32_valid, rdy32 = 1'b1, o32_last, o32_user;

    logic [63:0] m64_data = '0;
    logic [7:0]  m64_keep = '0;
    logic        m64_valid = 1'b0, m64_ready, m64_last = 1'b0, m64_user = 1'b0;
    logic [63:0] o64_data;
    logic [7:0]  o64_keep;
    logic        o64_valid, rdy64 = 1'b1, o64_last, o64_user;

`ifdef ETHERNET_RX_FCS_STATS_EN
    logic [15:0] fcs32, len32, fcs64, len64;
    int exp_fcs[2];
    int exp_len[2];
`endif

    beat_t q32[$];
    beat_t q64[$];
    int    tests = 0;
    int    fails = 0;
    int    stall64 = 0;
    bit    bp = 1'b0;
    bit    ignore32 = 1'b0;

    ethernet_rx_fcs_checker #(.data_width_p(32)) u_dut32 (
        .clk_i(clk), .reset_n_i(reset_n),
        .mac_axis_tdata_i(m32_data), .mac_axis_tkeep_i(m32_keep), .mac_axis_tvalid_i(m32_valid),
        .mac_axis_tready_o(m32_ready), .mac_axis_tlast_i(m32_last), .mac_axis_tuser_i(m32_user),
        .rx_axis_tdata_o(o32_data), .rx_axis_tkeep_o(o32_keep), .rx_axis_tvalid_o(o32_valid),
        .rx_axis_tready_i(rdy32), .rx_axis_tlast_o(o32_last), .rx_axis_tuser_o(o32_user)
`ifdef ETHERNET_RX_FCS_STATS_EN
        , .fcs_err_count_o(fcs32), .len_err_count_o(len32)
`endif
    );

    ethernet_rx_fcs_checker #(.data_width_p(64)) u_dut64 (
        .clk_i(clk), .reset_n_i(reset_n),
        .mac_axis_tdata_i(m64_data), .mac_axis_tkeep_i(m64_keep), .mac_axis_tvalid_i(m64_valid),
        .mac_axis_tready_o(m64_ready), .mac_axis_tlast_i(m64_last), .mac_axis_tuser_i(m64_user),
        .rx_axis_tdata_o(o64_data), .rx_axis_tkeep_o(o64_keep), .rx_axis_tvalid_o(o64_valid),
        .rx_axis_tready_i(rdy64), .rx_axis_tlast_o(o64_last), .rx_axis_tuser_o(o64_user)
`ifdef ETHERNET_RX_FCS_STATS_EN
        , .fcs_err_count_o(fcs64), .len_err_count_o(len64)
`endif
    );

    // Standard Ethernet FCS of the first n bytes (inverted, as transmitted).
    function automatic logic [31:0] ref_fcs(input byte_q f, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, f[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q make_frame(input int len);
        byte_q f;
        logic [31:0] c;
        for (int i = 0; i < len - 4; i++) f.push_back(8'($urandom));
        c = ref_fcs(f, len - 4);
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        return f;
    endfunction

    // Expected output: multi-beat frames lose their last 4 bytes; single-beat frames pass as bad.
    task automatic expect_frame(input int sel, input byte_q f, input bit merr);
        int    bw, len, olen;
        bit    fcs_bad, len_bad, user;
        beat_t e;
        bw  = sel ? 8 : 4;
        len = f.size();
        fcs_bad = (len < 4) || ({f[len-1], f[len-2], f[len-3], f[len-4]} != ref_fcs(f, len - 4));
        len_bad = (len < 64) || (len > 1518);
        if (len <= bw) begin olen = len; user = 1'b1; end
        else begin olen = len - 4; user = merr | fcs_bad | len_bad; end
        for (int base = 0; base < olen; base += bw) begin
            e.data = '0; e.keep = '0;
            for (int b = 0; b < bw; b++) if (base + b < olen) begin
                e.data[8*b +: 8] = f[base + b];
                e.keep[b] = 1'b1;
            end
            e.last = (base + bw >= olen);
            e.user = e.last & user;
            if (sel == 1) q64.push_back(e); else q32.push_back(e);
        end
`ifdef ETHERNET_RX_FCS_STATS_EN
        exp_fcs[sel] += int'(fcs_bad);
        exp_len[sel] += int'(len_bad);
`endif
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic mon(input int sel, input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        beat_t e;
        logic [63:0] m;
        tests++;
        if ((sel == 1 && q64.size() == 0) || (sel == 0 && q32.size() == 0)) begin
            fails++;
            $display("FAIL beat_w%0d: got data=%h keep=%h last=%b user=%b, required no output", sel ? 64 : 32, d, k, l, u);
            return;
        end
        e = (sel == 1) ? q64.pop_front() : q32.pop_front();
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{e.keep[b]}};
        if (k !== e.keep || (d & m) !== (e.data & m) || l !== e.last || u !== e.user) begin
            fails++;
            $display("FAIL beat_w%0d: got data=%h keep=%h last=%b user=%b, required data=%h keep=%h last=%b user=%b",
                     sel ? 64 : 32, d & m, k, l, u, e.data & m, e.keep, e.last, e.user);
        end
    endtask

    task automatic send(input int sel, input byte_q f, input bit merr, input bit gaps, input int max_beats);
        int bw, len, nb, guard, idx;
        logic [63:0] d;
        logic [7:0]  kp;
        bit acc, last;
        bw  = sel ? 8 : 4;
        len = f.size();
        nb  = (len + bw - 1) / bw;
        for (int k = 0; k < nb && k < max_beats; k++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            d  = {$urandom, $urandom};
            kp = '0;
            for (int b = 0; b < bw; b++) begin
                idx = k * bw + b;
                if (idx < len) begin d[8*b +: 8] = f[idx]; kp[b] = 1'b1; end
            end
            last = (k == nb - 1);
            if (sel == 1) begin
                m64_data = d; m64_keep = kp; m64_last = last; m64_user = merr & last; m64_valid = 1'b1;
            end else begin
                m32_data = d[31:0]; m32_keep = kp[3:0]; m32_last = last; m32_user = merr & last; m32_valid = 1'b1;
            end
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = (sel == 1) ? m64_ready : m32_ready;
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 2000) begin
                    tests++; fails++;
                    $display("FAIL accept_timeout w%0d beat %0d: ready stayed 0, required 1", sel ? 64 : 32, k);
                    m32_valid = 1'b0; m64_valid = 1'b0;
                    return;
                end
            end
            m32_valid = 1'b0;
            m64_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q32.size() != 0 || q64.size() != 0) && g < 5000) begin @(posedge clk); #1; g++; end
        check("drain_pending_beats", 64'(q32.size() + q64.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int sel, input int len, input bit corrupt, input bit merr, input bit gaps);
        byte_q f;
        int i;
        f = make_frame(len);
        if (corrupt) begin
            i = $urandom_range(0, len - 5);
            f[i] = f[i] ^ (8'h01 << $urandom_range(0, 7));
        end
        expect_frame(sel, f, merr);
        send(sel, f, merr, gaps, 1 << 30);
    endtask

    initial forever begin
        @(posedge clk); #1;
        rdy32 = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        rdy64 = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (m64_valid && !m64_ready) stall64++;
        if (reset_n && o32_valid && rdy32 && !ignore32) mon(0, {32'h0, o32_data}, {4'h0, o32_keep}, o32_last, o32_user);
        if (reset_n && o64_valid && rdy64) mon(1, o64_data, o64_keep, o64_last, o64_user);
    end

    initial begin
        byte_q f1, f2;
        #1 reset_n = 1'b0;
        #1;
        check("reset_tvalid_w32", 64'(o32_valid), 64'd0);
        check("reset_tvalid_w64", 64'(o64_valid), 64'd0);
        check("reset_tready_w32", 64'(m32_ready), 64'd0);
        check("reset_tready_w64", 64'(m64_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        f1 = make_frame(64);
        expect_frame(0, f1, 1'b0);
        send(0, f1, 1'b0, 1'b0, 1 << 30);
        f2 = f1;
        f2[10] = f2[10] ^ 8'h04;
        expect_frame(0, f2, 1'b0);
        send(0, f2, 1'b0, 1'b0, 1 << 30);
        drain();

        stall64 = 0;
        run_frame(1, 67, 1'b0, 1'b0, 1'b0);
        run_frame(1, 67, 1'b0, 1'b0, 1'b0);
        drain();
        check("stall_w64_67B", 64'(stall64), 64'd0);
        stall64 = 0;
        run_frame(1, 70, 1'b0, 1'b0, 1'b0);
        run_frame(1, 67, 1'b0, 1'b0, 1'b0);
        drain();
        check("stall_w64_70B", 64'(stall64), 64'd1);

        run_frame(0, 40, 1'b0, 1'b0, 1'b0);
        run_frame(0, 1600, 1'b0, 1'b0, 1'b0);
        run_frame(0, 80, 1'b0, 1'b1, 1'b0);
        run_frame(0, 5, 1'b0, 1'b0, 1'b0);
        run_frame(0, 8, 1'b0, 1'b0, 1'b0);
        run_frame(1, 6, 1'b0, 1'b0, 1'b0);
        run_frame(1, 8, 1'b0, 1'b0, 1'b0);
        run_frame(1, 9, 1'b0, 1'b0, 1'b0);
        run_frame(1, 12, 1'b0, 1'b0, 1'b0);
        run_frame(1, 13, 1'b0, 1'b0, 1'b0);
        run_frame(1, 63, 1'b0, 1'b0, 1'b0);
        run_frame(1, 64, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1518, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1519, 1'b0, 1'b0, 1'b0);
        drain();

        bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 1500 + $urandom_range(0, 30) : 9 + $urandom_range(0, 119);
            run_frame(i % 2, len, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 1'b1);
        end
        drain();

        ignore32 = 1'b1;
        f1 = make_frame(100);
        send(0, f1, 1'b0, 1'b0, 5);
        reset_n = 1'b0;
        #1;
        check("midreset_tvalid_w32", 64'(o32_valid), 64'd0);
        check("midreset_tready_w32", 64'(m32_ready), 64'd0);
        check("midreset_tvalid_w64", 64'(o64_valid), 64'd0);
`ifdef ETHERNET_RX_FCS_STATS_EN
        exp_fcs[0] = 0; exp_fcs[1] = 0; exp_len[0] = 0; exp_len[1] = 0;
`endif
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 ignore32 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            int len;
            len = 9 + $urandom_range(0, 150);
            run_frame(i % 2, len, $urandom_range(0, 3) == 0, 1'b0, 1'b1);
        end
        drain();

`ifdef ETHERNET_RX_FCS_STATS_EN
        check("fcs_err_count_w32", 64'(fcs32), 64'(exp_fcs[0]));
        check("len_err_count_w32", 64'(len32), 64'(exp_len[0]));
        check("fcs_err_count_w64", 64'(fcs64), 64'(exp_fcs[1]));
        check("len_err_count_w64", 64'(len64), 64'(exp_len[1]));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
